// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run/pause/lap sequencer.
// State encodings, default widths and the pointer-width helper.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_HOLD  = 2'd2,
      S_PAUSE = 2'd3
   } sw_state_t;

   localparam int VAL_W_DEF     = 16;
   localparam int LAP_DEPTH_DEF = 4;
   localparam int CNT_W         = 5;

   // Index width for a store of n entries; never narrower than one bit.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/sw_lap_buffer.sv
// Circular lap store: writes at wr_ptr, oldest entry overwritten when full,
// entry count saturates at DEPTH; clr empties it in one cycle.
module sw_lap_buffer
   import stopwatch_pkg::*;
#(
   parameter int DEPTH = LAP_DEPTH_DEF,
   parameter int VAL_W = VAL_W_DEF,
   parameter int PW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_p,
   input  logic             wr_en,
   input  logic             clr,
   input  logic [VAL_W-1:0] wr_data,
   input  logic [PW-1:0]    rd_idx,
   output logic [VAL_W-1:0] rd_data,
   output logic [PW-1:0]    wr_ptr,
   output logic [CNT_W-1:0] count
);

   // Storage is sized to the full index range so every rd_idx value is in bounds.
   localparam int SLOTS = 1 << PW;

   logic [VAL_W-1:0] r_mem [SLOTS];
   logic [PW-1:0]    r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (wr_en) begin
         r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         if (r_count != CNT_W'(DEPTH))
            r_count <= r_count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         r_mem[r_wr_ptr] <= wr_data;
   end

   assign rd_data = r_mem[rd_idx];
   assign wr_ptr  = r_wr_ptr;
   assign count   = r_count;

endmodule

// File: rtl/stopwatch_run_ctrl.sv
// Run/pause/lap/clear sequencer: gates the usec tick, issues counter clear, owns lap buffer.
// Optional feature macro LAP_RECALL_EN: multi-entry lap buffer with recall view in PAUSE.
module stopwatch_run_ctrl
   import stopwatch_pkg::*;
#(
   parameter int LAP_DEPTH = LAP_DEPTH_DEF,
   parameter int VAL_W     = VAL_W_DEF
) (
   input  logic             clk,
   input  logic             reset_p,
   input  logic             start_pulse,
   input  logic             lap_pulse,
   input  logic             recall_pulse,
   input  logic             tick_in,
   input  logic [VAL_W-1:0] time_now,
   output logic             tick_out,
   output logic             cnt_en,
   output logic             clr,
   output logic [VAL_W-1:0] disp_value,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] lap_count
);

`ifdef LAP_RECALL_EN
   localparam int LAP_D = LAP_DEPTH;
   logic w_recall_req;
   assign w_recall_req = recall_pulse;
`else
   // Recall disabled: the store collapses to a single register.
   localparam int LAP_D = LAP_DEPTH - LAP_DEPTH + 1;
   logic w_recall_req;
   logic w_unused_recall;
   assign w_recall_req    = 1'b0;
   assign w_unused_recall = recall_pulse;
`endif

   localparam int PW = clog2(LAP_D);

   sw_state_t        r_state, w_state_next;
   logic             r_clr, w_clr_next;
   logic [VAL_W-1:0] r_hold, w_hold_next;
   logic             r_recall, w_recall_next;
   logic [PW-1:0]    r_rd_idx, w_rd_idx_next;
   logic             w_push;

   logic [VAL_W-1:0] w_lap_rd;
   logic [PW-1:0]    w_wr_ptr;
   logic [CNT_W-1:0] w_lap_count;
   logic [PW-1:0]    w_newest, w_oldest, w_older;

   sw_lap_buffer #(
      .DEPTH (LAP_D),
      .VAL_W (VAL_W),
      .PW    (PW)
   ) u_lap_buffer (
      .clk     (clk),
      .reset_p (reset_p),
      .wr_en   (w_push),
      .clr     (w_clr_next),
      .wr_data (time_now),
      .rd_idx  (r_rd_idx),
      .rd_data (w_lap_rd),
      .wr_ptr  (w_wr_ptr),
      .count   (w_lap_count)
   );

   // Newest entry sits just behind wr_ptr; oldest is slot 0 until the store wraps.
   assign w_newest = (w_wr_ptr == '0) ? PW'(LAP_D - 1) : w_wr_ptr - 1'b1;
   assign w_oldest = (w_lap_count == CNT_W'(LAP_D)) ? w_wr_ptr : '0;
   assign w_older  = (r_rd_idx == '0) ? PW'(LAP_D - 1) : r_rd_idx - 1'b1;

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_state  <= S_IDLE;
         r_clr    <= 1'b0;
         r_hold   <= '0;
         r_recall <= 1'b0;
         r_rd_idx <= '0;
      end else begin
         r_state  <= w_state_next;
         r_clr    <= w_clr_next;
         r_hold   <= w_hold_next;
         r_recall <= w_recall_next;
         r_rd_idx <= w_rd_idx_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_clr_next    = 1'b0;
      w_hold_next   = r_hold;
      w_recall_next = r_recall;
      w_rd_idx_next = r_rd_idx;
      w_push        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_pulse)
               w_state_next = S_RUN;
         end
         S_RUN, S_HOLD: begin
            // start has priority; a coincident lap is dropped
            if (start_pulse) begin
               w_state_next = S_PAUSE;
            end else if (lap_pulse) begin
               w_push       = 1'b1;
               w_hold_next  = time_now;
               w_state_next = S_HOLD;
            end
         end
         S_PAUSE: begin
            if (start_pulse) begin
               w_state_next  = S_RUN;
               w_recall_next = 1'b0;
            end else if (lap_pulse) begin
               w_state_next  = S_IDLE;
               w_clr_next    = 1'b1;
               w_recall_next = 1'b0;
               w_rd_idx_next = '0;
            end else if (w_recall_req && (w_lap_count != '0)) begin
               w_recall_next = 1'b1;
               if (!r_recall)
                  w_rd_idx_next = w_newest;
               else
                  w_rd_idx_next = (r_rd_idx == w_oldest) ? w_newest : w_older;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      disp_value = time_now;
      if (r_state == S_HOLD)
         disp_value = r_hold;
      else if ((r_state == S_PAUSE) && r_recall)
         disp_value = w_lap_rd;
   end

   assign cnt_en    = (r_state == S_RUN) || (r_state == S_HOLD);
   assign tick_out  = tick_in & cnt_en;
   assign clr       = r_clr;
   assign state_o   = r_state;
   assign lap_count = w_lap_count;

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// Bench for stopwatch_run_ctrl: fixed vector table, directed corner sequences,
// then randomized pulses checked against a queue-based reference model.
module tb_stopwatch_run_ctrl;

`ifdef LAP_RECALL_EN
   localparam int DEPTH  = 4;
   localparam bit RECALL = 1'b1;
`else
   localparam int DEPTH  = 1;
   localparam bit RECALL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_p = 1'b1;
   logic        start_pulse = 1'b0;
   logic        lap_pulse = 1'b0;
   logic        recall_pulse = 1'b0;
   logic        tick_in = 1'b0;
   logic [15:0] time_now = 16'h0000;
   logic        tick_out, cnt_en, clr;
   logic [15:0] disp_value;
   logic [1:0]  state_o;
   logic [4:0]  lap_count;

   stopwatch_run_ctrl dut (
      .clk          (clk),
      .reset_p      (reset_p),
      .start_pulse  (start_pulse),
      .lap_pulse    (lap_pulse),
      .recall_pulse (recall_pulse),
      .tick_in      (tick_in),
      .time_now     (time_now),
      .tick_out     (tick_out),
      .cnt_en       (cnt_en),
      .clr          (clr),
      .disp_value   (disp_value),
      .state_o      (state_o),
      .lap_count    (lap_count)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: mode number 0 idle,1 run,2 hold,3 pause; laps kept oldest-first.
   int          m_mode;
   logic [15:0] m_laps[$];
   int          m_view;   // -1: live view, else age from newest lap
   logic [15:0] m_hold;
   bit          m_clr;

   task automatic model_reset();
      m_mode = 0;
      m_laps.delete();
      m_view = -1;
      m_hold = 16'h0000;
      m_clr  = 1'b0;
   endtask

   task automatic model_edge(input bit s, input bit l, input bit r, input logic [15:0] t);
      m_clr = 1'b0;
      case (m_mode)
         0: if (s) m_mode = 1;
         1, 2: begin
            if (s) m_mode = 3;
            else if (l) begin
               m_laps.push_back(t);
               if (m_laps.size() > DEPTH) void'(m_laps.pop_front());
               m_hold = t;
               m_mode = 2;
            end
         end
         default: begin
            if (s) begin
               m_mode = 1;
               m_view = -1;
            end else if (l) begin
               m_laps.delete();
               m_clr  = 1'b1;
               m_mode = 0;
               m_view = -1;
            end else if (r && RECALL && m_laps.size() > 0) begin
               m_view = (m_view + 1) % m_laps.size();
            end
         end
      endcase
   endtask

   function automatic logic [15:0] model_disp();
      if (m_mode == 2) return m_hold;
      if (m_mode == 3 && m_view >= 0) return m_laps[m_laps.size() - 1 - m_view];
      return time_now;
   endfunction

   task automatic check_model(input string tag);
      bit en;
      en = (m_mode == 1) || (m_mode == 2);
      chk({tag, ".state"}, 32'(state_o), 32'(m_mode));
      chk({tag, ".cnt_en"}, 32'(cnt_en), 32'(en));
      chk({tag, ".clr"}, 32'(clr), 32'(m_clr));
      chk({tag, ".lap_count"}, 32'(lap_count), 32'(m_laps.size()));
      chk({tag, ".disp"}, 32'(disp_value), 32'(model_disp()));
      chk({tag, ".tick_out"}, 32'(tick_out), 32'(tick_in & en));
   endtask

   // One clock: drive inputs, advance the model, sample 1ns after the edge.
   task automatic cyc(input bit s, input bit l, input bit r, input logic [15:0] t, input bit tk);
      start_pulse  = s;
      lap_pulse    = l;
      recall_pulse = r;
      time_now     = t;
      tick_in      = tk;
      model_edge(s, l, r, t);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start_pulse  = 1'b0;
      lap_pulse    = 1'b0;
      recall_pulse = 1'b0;
      tick_in      = 1'b0;
      reset_p      = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset_p = 1'b0;
   endtask

   typedef struct {
      bit          s;
      bit          l;
      logic [15:0] t;
      logic [1:0]  st;
      logic [4:0]  cnt;
      logic [15:0] disp;
      bit          clr;
      bit          en;
   } vec_t;

   vec_t tbl[17];

   initial begin
      logic [4:0]  c2;
      logic [15:0] rec_exp[5];
      int          ticks;

      c2 = (DEPTH >= 2) ? 5'd2 : 5'd1;
      tbl[0]  = '{1'b1, 1'b0, 16'h0000, 2'd1, 5'd0, 16'h0000, 1'b0, 1'b1};
      tbl[1]  = '{1'b0, 1'b0, 16'h0342, 2'd1, 5'd0, 16'h0342, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b0, 16'h0342, 2'd3, 5'd0, 16'h0342, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 16'h0342, 2'd3, 5'd0, 16'h0342, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 16'h1250, 2'd1, 5'd0, 16'h1250, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 16'h1250, 2'd2, 5'd1, 16'h1250, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 16'h1300, 2'd2, 5'd1, 16'h1250, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 16'h1499, 2'd2, c2,   16'h1499, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 16'h1520, 2'd2, c2,   16'h1499, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 16'h1530, 2'd3, c2,   16'h1530, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 16'h1530, 2'd3, c2,   16'h1530, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 16'h1530, 2'd0, 5'd0, 16'h1530, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 16'h1530, 2'd0, 5'd0, 16'h1530, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 16'h1540, 2'd0, 5'd0, 16'h1540, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 16'h1540, 2'd1, 5'd0, 16'h1540, 1'b0, 1'b1};
      tbl[15] = '{1'b1, 1'b1, 16'h1600, 2'd3, 5'd0, 16'h1600, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 1'b1, 16'h1600, 2'd0, 5'd0, 16'h1600, 1'b1, 1'b0};

      // Reset state while reset is held
      time_now = 16'h0abc;
      tick_in  = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset.state", 32'(state_o), 32'd0);
      chk("reset.cnt_en", 32'(cnt_en), 32'd0);
      chk("reset.clr", 32'(clr), 32'd0);
      chk("reset.lap_count", 32'(lap_count), 32'd0);
      chk("reset.disp", 32'(disp_value), 32'h0abc);
      chk("reset.tick_out", 32'(tick_out), 32'd0);
      do_reset();

      // Fixed vector table
      for (int i = 0; i < 17; i++) begin
         cyc(tbl[i].s, tbl[i].l, 1'b0, tbl[i].t, 1'b1);
         $display("vec %0d: start=%0d lap=%0d time=%h -> state=%0d laps=%0d disp=%h clr=%0d",
                  i, tbl[i].s, tbl[i].l, tbl[i].t, state_o, lap_count, disp_value, clr);
         chk($sformatf("vec%0d.state", i), 32'(state_o), 32'(tbl[i].st));
         chk($sformatf("vec%0d.lap_count", i), 32'(lap_count), 32'(tbl[i].cnt));
         chk($sformatf("vec%0d.disp", i), 32'(disp_value), 32'(tbl[i].disp));
         chk($sformatf("vec%0d.clr", i), 32'(clr), 32'(tbl[i].clr));
         chk($sformatf("vec%0d.cnt_en", i), 32'(cnt_en), 32'(tbl[i].en));
         chk($sformatf("vec%0d.tick_out", i), 32'(tick_out), 32'(tbl[i].en));
      end

      // 1000 ticks in, 1000 ticks out
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk("run.cnt_en", 32'(cnt_en), 32'd1);
      ticks = 0;
      for (int i = 0; i < 1000; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
         if (tick_out) ticks++;
      end
      chk("run.tick_count", 32'(ticks), 32'd1000);
      cyc(1'b1, 1'b0, 1'b0, 16'h0342, 1'b1);
      $display("run: ticks=%0d state after stop=%0d", ticks, state_o);
      chk("stop.tick_out", 32'(tick_out), 32'd0);
      chk("stop.disp", 32'(disp_value), 32'h0342);

      // Six laps, then recall walk from PAUSE
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      for (int i = 1; i <= 6; i++)
         cyc(1'b0, 1'b1, 1'b0, 16'(i), 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 16'h0777, 1'b0);
      chk("six_laps.lap_count", 32'(lap_count), 32'(DEPTH));
      if (RECALL) begin
         rec_exp[0] = 16'h0006; rec_exp[1] = 16'h0005; rec_exp[2] = 16'h0004;
         rec_exp[3] = 16'h0003; rec_exp[4] = 16'h0006;
      end else begin
         for (int i = 0; i < 5; i++) rec_exp[i] = 16'h0777;
      end
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 16'h0777, 1'b0);
         $display("recall %0d: disp=%h laps=%0d", i, disp_value, lap_count);
         chk($sformatf("recall%0d.disp", i), 32'(disp_value), 32'(rec_exp[i]));
      end
      cyc(1'b1, 1'b0, 1'b0, 16'h0800, 1'b0);
      chk("recall_exit.disp", 32'(disp_value), 32'h0800);
      cyc(1'b1, 1'b0, 1'b0, 16'h0810, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 16'h0810, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 16'h0810, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 16'h0820, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 16'h0821, 1'b0);
      chk("recall_empty.disp", 32'(disp_value), 32'h0821);
      check_model("recall_empty");

      // Asynchronous reset in the middle of HOLD
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 16'h0500, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 16'h0555, 1'b1);
      time_now = 16'h0600;
      @(negedge clk);
      #2;
      reset_p = 1'b1;
      #1;
      chk("async_rst.state", 32'(state_o), 32'd0);
      chk("async_rst.cnt_en", 32'(cnt_en), 32'd0);
      chk("async_rst.lap_count", 32'(lap_count), 32'd0);
      chk("async_rst.disp", 32'(disp_value), 32'h0600);
      chk("async_rst.tick_out", 32'(tick_out), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("async_rst.clr%0d", i), 32'(clr), 32'd0);
      end
      $display("async reset: state=%0d laps=%0d clr=%0d", state_o, lap_count, clr);
      do_reset();

      // Randomized pulses against the model
      for (int i = 0; i < 600; i++) begin
         bit s, l, r, tk;
         s  = ($urandom_range(7) == 0);
         l  = ($urandom_range(4) == 0);
         r  = ($urandom_range(2) == 0);
         tk = $urandom_range(1) == 1;
         cyc(s, l, r, 16'($urandom), tk);
         check_model($sformatf("rand%0d", i));
      end
      $display("random: 600 cycles, final state=%0d laps=%0d", state_o, lap_count);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
